// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the SDF FFT stage control path.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} stage_st_e;

    localparam logic OUT_SEL_SUM  = 1'b0;
    localparam logic OUT_SEL_DIFF = 1'b1;
    localparam int   TW_QUADS     = 4;

    typedef struct packed {
        logic bfly_en;
        logic sr_shift;
        logic out_sel;
        logic out_valid;
        logic out_sof;
        logic frame_done;
        logic sof_err;
    } stage_ctrl_t;

endpackage

// File: rtl/tw_addr_gen.sv
// Twiddle ROM address from stage position: top two beat-counter bits during BFLY/DRAIN.
// Latency: combinational.
// Backpressure: none, pure decode.
module tw_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int CW = 4
) (
    input  stage_st_e        state,
    input  logic [CW-1:0]    cnt,
    output logic [1:0]       tw_addr
);

    always_comb begin
        tw_addr = 2'd0;
        if (state == BFLY || state == DRAIN) begin
            tw_addr = cnt[CW-1:CW-2];
        end
    end

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill, butterfly and drain half-frames.
// Latency: control strobes are a zero-latency decode of registered state/cnt and the accepted beat.
// Backpressure: in_ready drops for the HALF-cycle drain and whenever cfg_en is low.
module fft_sdf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int BEATS = 32,
    parameter int FCW   = 16
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cfg_en,
    input  logic           in_valid,
    input  logic           in_sof,
    output logic           in_ready,
    output logic           bfly_en,
    output logic           sr_shift,
    output logic           out_sel,
    output logic [1:0]     tw_addr,
    output logic           out_valid,
    output logic           out_sof,
    output logic           frame_done,
    output logic           sof_err,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt
);

    localparam int HALF = BEATS / 2;
    localparam int CW   = $clog2(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    stage_st_e   state;
    logic [CW-1:0] cnt;
    stage_ctrl_t ctl;
    logic        acc;
    logic        last;
    logic        mis_sof;

    always_comb begin
        in_ready = cfg_en && (state != DRAIN);
        acc      = in_valid && in_ready;
        last     = (cnt == LAST);
        // A sof anywhere but a half-frame boundary restarts the frame from this beat
        mis_sof  = acc && in_sof && (state == FILL || state == BFLY) && (cnt != '0);
        ctl      = '0;
        if (cfg_en) begin
            case (state)
                IDLE:  ctl.sr_shift = acc && in_sof;
                FILL:  ctl.sr_shift = acc;
                BFLY: begin
                    ctl.sr_shift = acc;
                    ctl.out_sel  = OUT_SEL_SUM;
                    if (acc && !mis_sof) begin
                        ctl.bfly_en   = 1'b1;
                        ctl.out_valid = 1'b1;
                        ctl.out_sof   = (cnt == '0);
                    end
                end
                DRAIN: begin
                    ctl.sr_shift   = 1'b1;
                    ctl.out_sel    = OUT_SEL_DIFF;
                    ctl.out_valid  = 1'b1;
                    ctl.frame_done = last;
                end
            endcase
        end
        ctl.sof_err = mis_sof;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_cnt <= '0;
        end else if (!cfg_en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc && in_sof) begin
                        state <= FILL;
                        cnt   <= CW'(1);
                    end
                end
                FILL, BFLY: begin
                    if (mis_sof) begin
                        state <= FILL;
                        cnt   <= CW'(1);
                    end else if (acc) begin
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            cnt   <= '0;
                            state <= (state == FILL) ? BFLY : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        frame_cnt <= frame_cnt + FCW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    tw_addr_gen #(.CW(CW)) u_tw (
        .state   (state),
        .cnt     (cnt),
        .tw_addr (tw_addr)
    );

    assign bfly_en    = ctl.bfly_en;
    assign sr_shift   = ctl.sr_shift;
    assign out_sel    = ctl.out_sel;
    assign out_valid  = ctl.out_valid;
    assign out_sof    = ctl.out_sof;
    assign frame_done = ctl.frame_done;
    assign sof_err    = ctl.sof_err;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Bench for fft_sdf_stage_ctrl: vector table, corner sequences and a frame-position reference model.
module tb_fft_sdf_stage_ctrl;

    localparam int BEATS = 32;
    localparam int HALF  = BEATS / 2;
    localparam int FCW   = 6;

    logic clk = 1'b0;
    logic rstn, cfg_en, in_valid, in_sof;
    logic in_ready, bfly_en, sr_shift, out_sel, out_valid, out_sof, frame_done, sof_err, busy;
    logic [1:0]     tw_addr;
    logic [FCW-1:0] frame_cnt;

    always #5 clk = ~clk;

    fft_sdf_stage_ctrl #(.BEATS(BEATS), .FCW(FCW)) dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .bfly_en(bfly_en), .sr_shift(sr_shift), .out_sel(out_sel),
        .tw_addr(tw_addr), .out_valid(out_valid), .out_sof(out_sof), .frame_done(frame_done),
        .sof_err(sof_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int errors = 0;
    int n_ov, n_osof, n_done;

    // Reference model: position of the frame in accepted beats, then drain steps
    bit m_active, m_acc, m_err;
    int m_pos, m_drain, m_frames;
    bit e_rdy, e_shift, e_bfly, e_sel, e_ov, e_osof, e_done, e_serr, e_busy;
    int e_tw, e_fcnt;

    typedef struct {
        bit v, s;
        bit rdy, shift, bfly, sel, ov, osof, done;
        int tw;
    } vec_t;
    vec_t tbl[52];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pos = 0; m_drain = 0; m_frames = 0;
    endtask

    task automatic model_eval();
        bit draining;
        draining = m_active && (m_pos == BEATS);
        e_rdy  = cfg_en && !draining;
        m_acc  = in_valid && e_rdy;
        m_err  = 0;
        e_shift = 0; e_bfly = 0; e_sel = 0; e_ov = 0; e_osof = 0; e_done = 0; e_serr = 0; e_tw = 0;
        e_busy = m_active;
        e_fcnt = m_frames % (1 << FCW);
        if (cfg_en) begin
            if (!m_active) begin
                e_shift = m_acc && in_sof;
            end else if (!draining) begin
                if (m_pos >= HALF) e_tw = (m_pos - HALF) * 4 / HALF;
                if (m_acc) begin
                    m_err   = in_sof && (m_pos != HALF);
                    e_serr  = m_err;
                    e_shift = 1;
                    if (!m_err && m_pos >= HALF) begin
                        e_bfly = 1; e_ov = 1; e_osof = (m_pos == HALF);
                    end
                end
            end else begin
                e_tw = m_drain * 4 / HALF;
                e_shift = 1; e_sel = 1; e_ov = 1; e_done = (m_drain == HALF - 1);
            end
        end
    endtask

    task automatic model_step();
        if (!cfg_en) begin
            m_active = 0; m_pos = 0; m_drain = 0;
        end else if (!m_active) begin
            if (m_acc && in_sof) begin m_active = 1; m_pos = 1; end
        end else if (m_pos < BEATS) begin
            if (m_acc) m_pos = m_err ? 1 : m_pos + 1;
            m_drain = 0;
        end else if (m_drain == HALF - 1) begin
            m_active = 0; m_pos = 0; m_drain = 0; m_frames++;
        end else begin
            m_drain++;
        end
    endtask

    task automatic check_model();
        chk("in_ready", in_ready, e_rdy);
        chk("sr_shift", sr_shift, e_shift);
        chk("bfly_en", bfly_en, e_bfly);
        chk("out_sel", out_sel, e_sel);
        chk("out_valid", out_valid, e_ov);
        chk("out_sof", out_sof, e_osof);
        chk("frame_done", frame_done, e_done);
        chk("sof_err", sof_err, e_serr);
        chk("busy", busy, e_busy);
        chk("frame_cnt", frame_cnt, e_fcnt);
        if (cfg_en) chk("tw_addr", tw_addr, e_tw);
    endtask

    task automatic cyc_begin(input bit c, input bit v, input bit s);
        cfg_en = c; in_valid = v; in_sof = s;
        @(negedge clk);
        model_eval();
        check_model();
        if (out_valid) n_ov++;
        if (out_sof) n_osof++;
        if (frame_done) n_done++;
    endtask

    task automatic cyc_end();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit c, input bit v, input bit s);
        cyc_begin(c, v, s);
        cyc_end();
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_strobes", {bfly_en, sr_shift, out_sel, out_valid, out_sof, frame_done, sof_err}, 0);
        chk("rst_tw_addr", tw_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
    endtask

    task automatic full_frame();
        cyc(1, 1, 1);
        for (int i = 1; i < BEATS; i++) cyc(1, 1, 0);
        for (int i = 0; i < HALF; i++) cyc(1, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        rstn = 0; cfg_en = 1; in_valid = 0; in_sof = 0;
        model_reset();
        #1;
        chk_reset_vals();
        #12 rstn = 1;
        @(posedge clk); #1;

        // Single frame trace; DRAIN rows keep in_valid high, trailing rows are sof-less IDLE beats
        for (int i = 0; i < 52; i++) begin
            tbl[i] = '{v: 1, s: (i == 0), rdy: 1, shift: 0, bfly: 0, sel: 0, ov: 0, osof: 0, done: 0, tw: 0};
            if (i < HALF) begin
                tbl[i].shift = 1;
            end else if (i < BEATS) begin
                tbl[i].shift = 1; tbl[i].bfly = 1; tbl[i].ov = 1;
                tbl[i].osof = (i == HALF); tbl[i].tw = (i - HALF) / 4;
            end else if (i < BEATS + HALF) begin
                tbl[i].rdy = 0; tbl[i].shift = 1; tbl[i].sel = 1; tbl[i].ov = 1;
                tbl[i].done = (i == BEATS + HALF - 1); tbl[i].tw = (i - BEATS) / 4;
            end
        end
        foreach (tbl[i]) begin
            cyc_begin(1, tbl[i].v, tbl[i].s);
            chk("t_in_ready", in_ready, tbl[i].rdy);
            chk("t_sr_shift", sr_shift, tbl[i].shift);
            chk("t_bfly_en", bfly_en, tbl[i].bfly);
            chk("t_out_sel", out_sel, tbl[i].sel);
            chk("t_out_valid", out_valid, tbl[i].ov);
            chk("t_out_sof", out_sof, tbl[i].osof);
            chk("t_frame_done", frame_done, tbl[i].done);
            chk("t_tw_addr", tw_addr, tbl[i].tw);
            cyc_end();
        end
        chk("t1_frame_cnt", frame_cnt, 1);

        // Alternating gaps through FILL and BFLY
        n_ov = 0; n_done = 0;
        cyc(1, 1, 1);
        for (int i = 1; i < BEATS; i++) begin
            cyc_begin(1, 0, 0);
            chk("gap_strobes", {sr_shift, bfly_en, out_valid, out_sof}, 0);
            cyc_end();
            cyc(1, 1, 0);
        end
        for (int i = 0; i < HALF + 2; i++) cyc(1, 0, 0);
        chk("gap_out_valid_cnt", n_ov, 2 * HALF);
        chk("gap_frame_done_cnt", n_done, 1);

        // Misplaced sof at BFLY beat 5
        fc = frame_cnt;
        cyc(1, 1, 1);
        for (int i = 1; i < HALF + 5; i++) cyc(1, 1, 0);
        cyc_begin(1, 1, 1);
        chk("ms_sof_err", sof_err, 1);
        chk("ms_bfly_en", bfly_en, 0);
        chk("ms_out_valid", out_valid, 0);
        chk("ms_sr_shift", sr_shift, 1);
        cyc_end();
        chk("ms_busy", busy, 1);
        chk("ms_frame_cnt", frame_cnt, fc);
        for (int i = 1; i < HALF; i++) cyc(1, 1, 0);
        cyc_begin(1, 1, 0);
        chk("ms_restart_out_sof", out_sof, 1);
        cyc_end();
        for (int i = 1; i < HALF; i++) cyc(1, 1, 0);
        for (int i = 0; i < HALF; i++) cyc(1, 1, 0);

        // cfg_en dropped at FILL cnt==7
        n_done = 0;
        cyc(1, 1, 1);
        for (int i = 1; i < 7; i++) cyc(1, 1, 0);
        cyc_begin(0, 1, 0);
        chk("cfg_in_ready", in_ready, 0);
        chk("cfg_sr_shift", sr_shift, 0);
        cyc_end();
        cyc_begin(1, 0, 0);
        chk("cfg_busy", busy, 0);
        cyc_end();
        for (int i = 0; i < BEATS; i++) cyc(1, 1, 0);
        chk("cfg_no_done", n_done, 0);

        // Async reset mid-DRAIN
        cyc(1, 1, 1);
        for (int i = 1; i < BEATS + 5; i++) cyc(1, 1, 0);
        in_valid = 0;
        rstn = 0;
        #1;
        model_reset();
        chk_reset_vals();
        #1 rstn = 1;
        @(posedge clk); #1;
        cyc(1, 0, 0);

        // Back-to-back frames through frame_cnt wrap
        n_osof = 0;
        for (int f = 1; f <= (1 << FCW) + 1; f++) begin
            full_frame();
            chk("wrap_out_sof_cnt", n_osof, f);
        end
        chk("wrap_frame_cnt", frame_cnt, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 3) != 0,
                m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
